// File: rtl/vga_mix_pkg.sv
// vga_mix_pkg: shared colour types, palette constants and layer config record for the mixer
package vga_mix_pkg;
   localparam int COLOR_W = 3;
   localparam int LAYERS  = 4;

   typedef logic [COLOR_W-1:0] color_t;

   localparam color_t BLACK   = 3'b000;
   localparam color_t RED     = 3'b100;
   localparam color_t GREEN   = 3'b010;
   localparam color_t BLUE    = 3'b001;
   localparam color_t YELLOW  = 3'b110;
   localparam color_t MAGENTA = 3'b101;
   localparam color_t CYAN    = 3'b011;
   localparam color_t WHITE   = 3'b111;

   typedef struct packed {
      logic [LAYERS-1:0] enable;
      logic [LAYERS-1:0] blink;
      color_t            bg;
   } cfg_t;

   localparam cfg_t CFG_RST = '{enable: '1, blink: '0, bg: BLACK};
endpackage

// File: rtl/mix_frame_timer.sv
// mix_frame_timer: frame tick from vsync falling edge, blink phase and flash duration counters
module mix_frame_timer #(
   parameter int BLINK_FRAMES = 30,
   parameter int FLASH_FRAMES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic vsync_in,
   input  logic flash_req,
   output logic frame_tick,
   output logic blink_phase,
   output logic flashing
);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam int FW = $clog2(FLASH_FRAMES + 2);

   logic          vs_prev_q, vs_prev_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic [FW-1:0] flash_cnt_q, flash_cnt_d;
   logic          flashing_q, flashing_d;
   logic          blink_wrap, flash_load;

   assign frame_tick  = vs_prev_q & ~vsync_in;
   assign blink_phase = blink_phase_q;
   assign flashing    = flashing_q;

   always_comb begin
      vs_prev_d     = vsync_in;
      blink_wrap    = blink_cnt_q == BW'(BLINK_FRAMES - 1);
      blink_cnt_d   = frame_tick ? (blink_wrap ? '0 : blink_cnt_q + 1'b1) : blink_cnt_q;
      blink_phase_d = blink_phase_q ^ (frame_tick & blink_wrap);
      flash_load    = flash_req && FLASH_FRAMES != 0;
      // a reload always beats a coincident tick decrement
      flash_cnt_d   = flash_load ? FW'(FLASH_FRAMES)
                    : (frame_tick && flash_cnt_q != '0) ? flash_cnt_q - 1'b1 : flash_cnt_q;
      flashing_d    = flash_load | (flashing_q & (flash_cnt_q != '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_prev_q     <= 1'b1;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         flash_cnt_q   <= '0;
         flashing_q    <= 1'b0;
      end else begin
         vs_prev_q     <= vs_prev_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         flash_cnt_q   <= flash_cnt_d;
         flashing_q    <= flashing_d;
      end
   end
endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: 2-stage fixed-priority layer compositor with frame-synchronous config,
// blink masks and full-screen flash
module vga_layer_mixer
   import vga_mix_pkg::*;
#(
   parameter int NUM_LAYERS   = LAYERS,
   parameter int COLOR_W      = vga_mix_pkg::COLOR_W,
   parameter int BLINK_FRAMES = 30,
   parameter int FLASH_FRAMES = 20
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
   input  logic [9:0]                    x_in,
   input  logic [9:0]                    y_in,
   input  logic                          hsync_in,
   input  logic                          vsync_in,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [NUM_LAYERS-1:0]         cfg_enable,
   input  logic [NUM_LAYERS-1:0]         cfg_blink,
   input  logic [COLOR_W-1:0]            cfg_bg,
   input  logic                          flash_req,
   output logic [COLOR_W-1:0]            color_out,
   output logic                          hsync_out,
   output logic                          vsync_out,
   output logic [9:0]                    x_out,
   output logic [9:0]                    y_out,
   output logic                          flashing
);
   logic [NUM_LAYERS*COLOR_W-1:0] lc1_q, lc1_d;
   logic [9:0]                    x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
   logic                          hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
   logic [COLOR_W-1:0]            color_q, color_d;
   cfg_t                          active_q, active_d, shadow_q, shadow_d;
   logic                          pending_q, pending_d;
   logic                          frame_tick, blink_phase;

   mix_frame_timer #(
      .BLINK_FRAMES(BLINK_FRAMES),
      .FLASH_FRAMES(FLASH_FRAMES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .vsync_in   (vsync_in),
      .flash_req  (flash_req),
      .frame_tick (frame_tick),
      .blink_phase(blink_phase),
      .flashing   (flashing)
   );

   // priority chain: each layer passes through the result of the layers behind it
   for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
      logic [COLOR_W-1:0] c, s;
      logic               v;
      assign c = lc1_q[i*COLOR_W +: COLOR_W];
      assign v = active_q.enable[i] && c != '0 && !(active_q.blink[i] && blink_phase);
      if (i == NUM_LAYERS - 1) begin : g_last
         assign s = v ? c : active_q.bg;
      end else begin : g_mid
         assign s = v ? c : g_layer[i+1].s;
      end
   end

   always_comb begin
      lc1_d     = layer_color;
      x1_d      = x_in;
      y1_d      = y_in;
      hs1_d     = hsync_in;
      vs1_d     = vsync_in;
      color_d   = flashing ? ~g_layer[0].s : g_layer[0].s;
      x2_d      = x1_q;
      y2_d      = y1_q;
      hs2_d     = hs1_q;
      vs2_d     = vs1_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (frame_tick && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end else if (cfg_valid && !pending_q) begin
         shadow_d  = '{enable: cfg_enable, blink: cfg_blink, bg: cfg_bg};
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lc1_q     <= '0;
         x1_q      <= '0;
         y1_q      <= '0;
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
         color_q   <= '0;
         x2_q      <= '0;
         y2_q      <= '0;
         hs2_q     <= 1'b1;
         vs2_q     <= 1'b1;
         active_q  <= CFG_RST;
         shadow_q  <= CFG_RST;
         pending_q <= 1'b0;
      end else begin
         lc1_q     <= lc1_d;
         x1_q      <= x1_d;
         y1_q      <= y1_d;
         hs1_q     <= hs1_d;
         vs1_q     <= vs1_d;
         color_q   <= color_d;
         x2_q      <= x2_d;
         y2_q      <= y2_d;
         hs2_q     <= hs2_d;
         vs2_q     <= vs2_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
      end
   end

   assign cfg_ready = !pending_q;
   assign color_out = color_q;
   assign x_out     = x2_q;
   assign y_out     = y2_q;
   assign hsync_out = hs2_q;
   assign vsync_out = vs2_q;
endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb_vga_layer_mixer: vector table, hand-written corner sequences and random run against a frame-level model
module tb_vga_layer_mixer;
   import vga_mix_pkg::*;
   localparam int BLINK = 2;
   localparam int FLASH = 3;

   logic        clk = 0, rst = 1;
   logic [11:0] layer_color = '0;
   logic [9:0]  x_in = '0, y_in = '0, x_out, y_out;
   logic        hsync_in = 1, vsync_in = 1, cfg_valid = 0, cfg_ready, flash_req = 0;
   logic [3:0]  cfg_enable = '1, cfg_blink = '0;
   logic [2:0]  cfg_bg = '0, color_out;
   logic        hsync_out, vsync_out, flashing;

   vga_layer_mixer #(.NUM_LAYERS(4), .COLOR_W(3), .BLINK_FRAMES(BLINK), .FLASH_FRAMES(FLASH)) dut (
      .clk(clk), .rst(rst), .layer_color(layer_color), .x_in(x_in), .y_in(y_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_enable(cfg_enable), .cfg_blink(cfg_blink), .cfg_bg(cfg_bg), .flash_req(flash_req),
      .color_out(color_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
      .x_out(x_out), .y_out(y_out), .flashing(flashing)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int tests = 0, fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: frame count drives blink, remaining flash frames, config mailbox
   int         ticks, flash_left;
   bit         m_prev_vs, flash_on, pend;
   logic [3:0] sh_en, sh_bl, ac_en, ac_bl;
   logic [2:0] sh_bg, ac_bg;
   logic [11:0] p_lc;
   logic [9:0] p_x, p_y, e_x, e_y;
   logic       p_hs, p_vs, e_hs, e_vs;
   logic [2:0] e_color;

   function automatic logic [2:0] comp(input logic [11:0] lc);
      bit ph = ((ticks / BLINK) % 2) == 1;
      comp = ac_bg;
      for (int i = 3; i >= 0; i--)
         if (ac_en[i] && lc[i*3 +: 3] != 3'b000 && !(ac_bl[i] && ph)) comp = lc[i*3 +: 3];
   endfunction

   task automatic m_reset();
      ticks = 0; flash_left = 0; m_prev_vs = 1; flash_on = 0; pend = 0;
      sh_en = '1; sh_bl = '0; sh_bg = '0; ac_en = '1; ac_bl = '0; ac_bg = '0;
      p_lc = '0; p_x = '0; p_y = '0; p_hs = 1; p_vs = 1;
      e_color = '0; e_x = '0; e_y = '0; e_hs = 1; e_vs = 1;
   endtask

   task automatic m_edge();
      bit tick = m_prev_vs && !vsync_in;
      e_color = comp(p_lc) ^ {3{flash_on}};
      e_x = p_x; e_y = p_y; e_hs = p_hs; e_vs = p_vs;
      p_lc = layer_color; p_x = x_in; p_y = y_in; p_hs = hsync_in; p_vs = vsync_in;
      m_prev_vs = vsync_in;
      if (tick) ticks++;
      if (flash_req) begin
         flash_left = FLASH; flash_on = 1;
      end else begin
         if (flash_left == 0) flash_on = 0;
         if (tick && flash_left > 0) flash_left--;
      end
      if (tick && pend) begin
         ac_en = sh_en; ac_bl = sh_bl; ac_bg = sh_bg; pend = 0;
      end else if (cfg_valid && !pend) begin
         sh_en = cfg_enable; sh_bl = cfg_blink; sh_bg = cfg_bg; pend = 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) m_reset(); else m_edge();
      #1;
      chk("pipe", {5'b0, color_out, x_out, y_out, hsync_out, vsync_out, flashing, cfg_ready},
          {5'b0, e_color, e_x, e_y, e_hs, e_vs, flash_on, !pend});
   endtask

   task automatic hold(input int n);
      repeat (n) step();
   endtask

   task automatic tick_frame();
      vsync_in = 0; step();
      vsync_in = 1; step();
   endtask

   task automatic load_cfg(input logic [3:0] en, input logic [3:0] bl, input logic [2:0] bg);
      if (!cfg_ready) tick_frame();
      chk("ready_before_load", {31'b0, cfg_ready}, 32'd1);
      cfg_valid = 1; cfg_enable = en; cfg_blink = bl; cfg_bg = bg;
      step();
      cfg_valid = 0;
      tick_frame();
   endtask

   task automatic do_reset();
      rst = 1; hold(2); rst = 0;
   endtask

   typedef struct {
      logic [3:0]  en;
      logic [2:0]  bg;
      logic [11:0] lc;
      logic [2:0]  exp;
   } vec_t;

   vec_t vt[7];
   logic [2:0] c_exp;

   initial begin
      vt[0] = '{4'b1111, BLACK,  {BLUE, GREEN, RED, BLACK},       RED};
      vt[1] = '{4'b1101, BLACK,  {BLUE, GREEN, RED, BLACK},       GREEN};
      vt[2] = '{4'b0000, MAGENTA,{BLUE, GREEN, RED, YELLOW},      MAGENTA};
      vt[3] = '{4'b1111, YELLOW, {BLACK, BLACK, BLACK, BLACK},    YELLOW};
      vt[4] = '{4'b1111, BLACK,  {WHITE, BLACK, BLACK, BLACK},    WHITE};
      vt[5] = '{4'b0111, CYAN,   {WHITE, BLACK, BLACK, BLACK},    CYAN};
      vt[6] = '{4'b1111, BLACK,  {BLACK, BLACK, BLUE, YELLOW},    YELLOW};

      hold(2);
      chk("rst_vals", {19'b0, color_out, x_out, y_out, hsync_out, vsync_out, flashing, cfg_ready}, 32'h0000_000D);
      rst = 0;
      hold(2);

      foreach (vt[k]) begin
         load_cfg(vt[k].en, 4'b0000, vt[k].bg);
         layer_color = vt[k].lc;
         hold(3);
         chk($sformatf("vec%0d", k), {29'b0, color_out}, {29'b0, vt[k].exp});
      end

      // exact 2-cycle latency with aligned coordinates and syncs
      load_cfg(4'b1111, 4'b0000, BLACK);
      layer_color = '0; hold(3);
      layer_color = {BLUE, GREEN, RED, BLACK}; x_in = 10'd123; y_in = 10'd45; hsync_in = 0;
      step();
      chk("lat1_color", {29'b0, color_out}, {29'b0, BLACK});
      layer_color = '0; x_in = 0; y_in = 0; hsync_in = 1;
      step();
      chk("lat2", {9'b0, color_out, x_out, y_out, hsync_out}, {9'b0, RED, 10'd123, 10'd45, 1'b0});

      // background change offered mid-frame waits for vsync fall
      hold(2);
      cfg_valid = 1; cfg_enable = '1; cfg_blink = '0; cfg_bg = BLUE; step(); cfg_valid = 0;
      hold(5);
      chk("bg_wait", {28'b0, color_out, cfg_ready}, {28'b0, BLACK, 1'b0});
      tick_frame(); hold(1);
      chk("bg_applied", {28'b0, color_out, cfg_ready}, {28'b0, BLUE, 1'b1});

      // handshake: second payload ignored while pending
      cfg_valid = 1; cfg_bg = GREEN; step();
      cfg_bg = RED; step(); step();
      cfg_valid = 0;
      chk("hs_busy", {31'b0, cfg_ready}, 32'd0);
      tick_frame(); hold(2);
      chk("hs_first", {28'b0, color_out, cfg_ready}, {28'b0, GREEN, 1'b1});
      cfg_valid = 1; cfg_bg = RED; step(); cfg_valid = 0;
      chk("hs_second_taken", {31'b0, cfg_ready}, 32'd0);
      tick_frame(); hold(2);
      chk("hs_second", {29'b0, color_out}, {29'b0, RED});

      // blink: frames counted from reset
      do_reset();
      layer_color = {BLACK, BLACK, GREEN, RED};
      load_cfg(4'b1111, 4'b0001, BLACK);
      hold(2);
      chk("blink_t1", {29'b0, color_out}, {29'b0, RED});
      for (int t = 2; t <= 7; t++) begin
         tick_frame(); hold(2);
         c_exp = ((t / 2) % 2) == 1 ? GREEN : RED;
         chk($sformatf("blink_t%0d", t), {29'b0, color_out}, {29'b0, c_exp});
      end

      // flash: 3 ticks, retrigger, coincident request
      load_cfg(4'b1111, 4'b0000, BLACK);
      layer_color = {BLACK, BLACK, BLACK, RED}; hold(3);
      flash_req = 1; step(); flash_req = 0;
      chk("fl_on", {31'b0, flashing}, 32'd1);
      hold(2);
      chk("fl_inv", {29'b0, color_out}, {29'b0, CYAN});
      tick_frame(); tick_frame();
      chk("fl_t2", {31'b0, flashing}, 32'd1);
      tick_frame(); hold(2);
      chk("fl_end", {28'b0, color_out, flashing}, {28'b0, RED, 1'b0});
      flash_req = 1; step(); flash_req = 0;
      tick_frame(); tick_frame();
      flash_req = 1; step(); flash_req = 0;
      tick_frame(); tick_frame();
      chk("fl_retrig", {28'b0, color_out, flashing}, {28'b0, CYAN, 1'b1});
      tick_frame(); hold(2);
      chk("fl_retrig_end", {31'b0, flashing}, 32'd0);
      flash_req = 1; vsync_in = 0; step(); flash_req = 0; vsync_in = 1; step();
      tick_frame(); tick_frame();
      chk("fl_coinc", {31'b0, flashing}, 32'd1);
      tick_frame(); hold(2);
      chk("fl_coinc_end", {31'b0, flashing}, 32'd0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         layer_color = 12'($urandom);
         x_in = 10'($urandom); y_in = 10'($urandom);
         hsync_in = $urandom_range(0, 7) != 0;
         vsync_in = $urandom_range(0, 20) != 0;
         cfg_valid = $urandom_range(0, 3) == 0;
         cfg_enable = 4'($urandom); cfg_blink = 4'($urandom); cfg_bg = 3'($urandom);
         flash_req = $urandom_range(0, 60) == 0;
         step();
      end
      cfg_valid = 0; flash_req = 0; vsync_in = 1; hsync_in = 1;
      hold(2);

      // asynchronous reset in the middle of a flash with config pending
      if (!cfg_ready) tick_frame();
      flash_req = 1; cfg_valid = 1; cfg_enable = 4'b0000; cfg_bg = WHITE; x_in = 10'd7;
      step();
      flash_req = 0; cfg_valid = 0;
      step();
      chk("pre_rst", {30'b0, flashing, cfg_ready}, 32'd2);
      #2 rst = 1;
      #1;
      chk("async_rst", {19'b0, color_out, x_out, y_out, hsync_out, vsync_out, flashing, cfg_ready}, 32'h0000_000D);
      step();
      rst = 0;
      step();
      chk("post_rst_ready", {31'b0, cfg_ready}, 32'd1);
      layer_color = '0; hold(3);
      chk("post_rst_bg", {29'b0, color_out}, {29'b0, BLACK});
      layer_color = {BLUE, BLACK, BLACK, BLACK}; hold(3);
      chk("post_rst_en", {29'b0, color_out}, {29'b0, BLUE});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
